mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
// - Memory-stage load/store unit: consumes the EX/MEM register outputs (RegWriteM, ResultSrcM, MemWriteM,
//   ALUResultM, WriteDataM, RdM, PCPlus4M), runs the data-memory handshake, produces MEM/WB-stage values.
// - Non-memory ops pass to W in 1 cycle; loads/stores stall the pipeline via StallM until memory responds.
// PARAMETERS
// - TIMEOUT   default 16   max WAIT cycles without mem_ready before abort (>=1)
// - CNT_W     default 5    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   reset, synchronous, active-high
// - RegWriteM    in   1   M-stage register-write enable
// - ResultSrcM   in   2   00 ALU, 01 load data, 10 PC+4; 01 marks a load
// - MemWriteM    in   1   M-stage store
// - ALUResultM   in   32  address for loads/stores, else result
// - WriteDataM   in   32  store data
// - RdM          in   32  destination register index (low 5 bits significant)
// - PCPlus4M     in   32  PC+4 of M-stage instruction
// - mem_req      out  1   memory request valid (registered)
// - mem_we       out  1   1 store, 0 load (registered)
// - mem_addr     out  32  word address = {ALUResultM[31:2],2'b00} (registered)
// - mem_wdata    out  32  store data (registered)
// - mem_ready    in   1   memory accepts/completes the request this cycle
// - mem_rdata    in   32  load data, valid when mem_ready=1
// - StallM       out  1   combinational; 1 freezes F/D/E stages and EX/MEM register
// - mem_err      out  1   1-cycle pulse on timeout (or misalign, see CONFIGURATION)
// - RegWriteW, ResultSrcW[2], ReadDataW[32], ALUResultW[32], RdW[32], PCPlus4W[32]   out   W-stage regs
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counter 0. Reset mid-WAIT drops mem_req at that edge; op discarded.
// - memop = MemWriteM | (ResultSrcM==2'b01).
// - IDLE, !memop: StallM=0; at edge W regs <= M inputs, ReadDataW <= 0. 1-cycle latency.
// - IDLE, memop: StallM=1; at edge mem_req<=1, mem_we<=MemWriteM, mem_addr/mem_wdata latched;
//   RegWriteW<=0 (bubble); counter<=0; -> WAIT.
// - WAIT, mem_ready=0: StallM=1; W bubble (RegWriteW=0, other W regs hold); counter++;
//   counter reaching TIMEOUT-1 -> abort: mem_req<=0, mem_err pulses next cycle, W bubble, -> IDLE,
//   StallM=0 in the abort cycle (instruction retires without write).
// - WAIT, mem_ready=1: StallM=0; at edge mem_req<=0; W regs <= M inputs, ReadDataW <= mem_rdata
//   (store: ReadDataW<=0, RegWriteW=RegWriteM i.e. 0); -> IDLE. Memory op minimum latency 2 cycles.
// - mem_ready while IDLE or mem_req=0 is ignored. mem_req, mem_addr, mem_we, mem_wdata stable in WAIT.
// - Back-to-back memops: each goes IDLE->WAIT->IDLE; no pipelining of requests.
// - ready and timeout in same cycle: ready wins (normal completion, no mem_err).
// - RdW/RegWriteW forced 0 for bubbles so forwarding never sees a stalled op twice.
// CONFIGURATION
// - LSU_MISALIGN_CHECK_EN defined: memop with ALUResultM[1:0]!=0 is not issued; stays IDLE, StallM=0,
//   W bubble (RegWriteW=0), mem_err pulses the next cycle.
// - Undefined: no check; low address bits dropped, access issued to the aligned word.
// TESTING
// - ALU op RegWriteM=1,RdM=5,ALUResultM=0x1234 -> next cycle RegWriteW=1,RdW=5,ALUResultW=0x1234,StallM never 1.
// - Load addr 0x100, mem_ready after 3 WAIT cycles, rdata=0xDEADBEEF -> mem_req=1 3 cycles, StallM=1 4 cycles,
//   then ReadDataW=0xDEADBEEF, RegWriteW=1, ResultSrcW=01.
// - Store addr 0x200 data 0xCAFE, ready first WAIT cycle -> mem_we=1,mem_addr=0x200,mem_wdata=0xCAFE, RegWriteW=0.
// - Load, mem_ready never -> after TIMEOUT=16 WAIT cycles mem_req=0, mem_err 1-cycle pulse, RegWriteW stays 0.
// - rst=1 during WAIT -> next edge mem_req=0, StallM=0, all W outputs 0.
// - With LSU_MISALIGN_CHECK_EN, load at 0x102 -> mem_req stays 0, mem_err pulse, RegWriteW=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory handshake and produces the MEM/WB registers.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject loads/stores that are not word aligned.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] RdM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        mem_err,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] RdW,
  output logic [31:0] PCPlus4W
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              memop_c;
  logic              misalign_c;
  logic              issue_c;
  logic              timeout_c;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_err_q, mem_err_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic [SRC_W-1:0]  result_src_w_q, result_src_w_d;
  logic [DATA_W-1:0] read_data_w_q, read_data_w_d;
  logic [DATA_W-1:0] alu_result_w_q, alu_result_w_d;
  logic [DATA_W-1:0] rd_w_q, rd_w_d;
  logic [DATA_W-1:0] pc_plus4_w_q, pc_plus4_w_d;

  assign memop_c = MemWriteM | (ResultSrcM == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = memop_c & (ALUResultM[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign issue_c   = memop_c & ~misalign_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready response outranks a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue_c) state_d = ST_WAIT;
      ST_WAIT: if (mem_ready || timeout_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall output; released in the completion and abort cycles so the op retires once
  always_comb begin
    StallM = 1'b0;
    case (state_q)
      ST_IDLE: StallM = issue_c;
      ST_WAIT: StallM = ~mem_ready & ~timeout_c;
      default: StallM = 1'b0;
    endcase
    if (rst) StallM = 1'b0;
  end

  // Registered datapath next values; bubbles zero RegWriteW and RdW so forwarding ignores them
  always_comb begin
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_err_d      = 1'b0;
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    read_data_w_d  = read_data_w_q;
    alu_result_w_d = alu_result_w_q;
    rd_w_d         = rd_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    case (state_q)
      ST_IDLE: begin
        if (misalign_c) begin
          mem_err_d     = 1'b1;
          reg_write_w_d = 1'b0;
          rd_w_d        = '0;
        end else if (issue_c) begin
          mem_req_d     = 1'b1;
          mem_we_d      = MemWriteM;
          mem_addr_d    = {ALUResultM[31:2], 2'b00};
          mem_wdata_d   = WriteDataM;
          cnt_d         = '0;
          reg_write_w_d = 1'b0;
          rd_w_d        = '0;
        end else begin
          reg_write_w_d  = RegWriteM;
          result_src_w_d = ResultSrcM;
          read_data_w_d  = '0;
          alu_result_w_d = ALUResultM;
          rd_w_d         = RdM;
          pc_plus4_w_d   = PCPlus4M;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          mem_req_d      = 1'b0;
          reg_write_w_d  = RegWriteM;
          result_src_w_d = ResultSrcM;
          read_data_w_d  = MemWriteM ? '0 : mem_rdata;
          alu_result_w_d = ALUResultM;
          rd_w_d         = RdM;
          pc_plus4_w_d   = PCPlus4M;
        end else if (timeout_c) begin
          mem_req_d     = 1'b0;
          mem_err_d     = 1'b1;
          reg_write_w_d = 1'b0;
          rd_w_d        = '0;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          reg_write_w_d = 1'b0;
          rd_w_d        = '0;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_err_q      <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      read_data_w_q  <= '0;
      alu_result_w_q <= '0;
      rd_w_q         <= '0;
      pc_plus4_w_q   <= '0;
    end else begin
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_err_q      <= mem_err_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      read_data_w_q  <= read_data_w_d;
      alu_result_w_q <= alu_result_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_err    = mem_err_q;
  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;
  assign ReadDataW  = read_data_w_q;
  assign ALUResultW = alu_result_w_q;
  assign RdW        = rd_w_q;
  assign PCPlus4W   = pc_plus4_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (default TIMEOUT=16).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, RdM, PCPlus4M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM, mem_err;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, RdW, PCPlus4W;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  int n;
  logic rw_seen;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .mem_err(mem_err),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
    .ALUResultW(ALUResultW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  // Cycle counters sampled mid-cycle
  always @(negedge clk) begin
    if (StallM) stall_cnt++;
    if (mem_req && !mem_ready) req_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [31:0] pc);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    ALUResultM = alu;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regwritew", 32'(RegWriteW), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    rst = 1'b0;

    // ALU op passes in one cycle
    set_op(1'b1, 2'b00, 1'b0, 32'h1234, 32'h0, 32'd5, 32'h44);
    #1 chk("alu_stall", 32'(StallM), 32'd0);
    step();
    chk("alu_regwritew", 32'(RegWriteW), 32'd1);
    chk("alu_rdw", RdW, 32'd5);
    chk("alu_resultw", ALUResultW, 32'h1234);
    chk("alu_pcw", PCPlus4W, 32'h44);
    chk("alu_readdataw", ReadDataW, 32'h0);
    chk("alu_mem_req", 32'(mem_req), 32'd0);

    // PC+4 result select with mem_ready asserted while idle (ignored)
    set_op(1'b1, 2'b10, 1'b0, 32'h55, 32'h0, 32'd9, 32'h88);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1 chk("idle_ready_stall", 32'(StallM), 32'd0);
    step();
    mem_ready = 1'b0;
    chk("idle_ready_req", 32'(mem_req), 32'd0);
    chk("idle_ready_readdataw", ReadDataW, 32'h0);
    chk("pc4_resultsrcw", 32'(ResultSrcW), 32'd2);
    chk("pc4_pcw", PCPlus4W, 32'h88);

    // Load at 0x100, ready after 3 waiting cycles
    stall_cnt = 0;
    req_cnt = 0;
    set_op(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 32'd7, 32'h80);
    #1 chk("ld_issue_stall", 32'(StallM), 32'd1);
    step();
    chk("ld_req", 32'(mem_req), 32'd1);
    chk("ld_we", 32'(mem_we), 32'd0);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_bubble_rw", 32'(RegWriteW), 32'd0);
    chk("ld_bubble_rd", RdW, 32'd0);
    repeat (3) step();
    chk("ld_req_hold", 32'(mem_req), 32'd1);
    chk("ld_addr_hold", mem_addr, 32'h100);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_done_stall", 32'(StallM), 32'd0);
    step();
    mem_ready = 1'b0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("ld_req_drop", 32'(mem_req), 32'd0);
    chk("ld_readdataw", ReadDataW, 32'hDEAD_BEEF);
    chk("ld_regwritew", 32'(RegWriteW), 32'd1);
    chk("ld_resultsrcw", 32'(ResultSrcW), 32'd1);
    chk("ld_rdw", RdW, 32'd7);
    chk("ld_pcw", PCPlus4W, 32'h80);
    chk("ld_err", 32'(mem_err), 32'd0);
    #5;
    chk("ld_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("ld_req_wait_cycles", 32'(req_cnt), 32'd3);
    step();

    // Store at 0x200, ready in first waiting cycle
    set_op(1'b0, 2'b00, 1'b1, 32'h200, 32'h0000_CAFE, 32'd3, 32'h90);
    step();
    chk("st_req", 32'(mem_req), 32'd1);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_addr", mem_addr, 32'h200);
    chk("st_wdata", mem_wdata, 32'h0000_CAFE);
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    mem_ready = 1'b0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("st_req_drop", 32'(mem_req), 32'd0);
    chk("st_regwritew", 32'(RegWriteW), 32'd0);
    chk("st_readdataw", ReadDataW, 32'h0);
    step();

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned load is rejected with an error pulse
    set_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 32'd4, 32'hA0);
    #1 chk("mis_stall", 32'(StallM), 32'd0);
    step();
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_err", 32'(mem_err), 32'd1);
    chk("mis_regwritew", 32'(RegWriteW), 32'd0);
    step();
    chk("mis_err_pulse", 32'(mem_err), 32'd0);
`else
    // Unaligned store goes to the aligned word
    set_op(1'b0, 2'b00, 1'b1, 32'h207, 32'h0000_0BAD, 32'd0, 32'hA0);
    step();
    chk("ua_req", 32'(mem_req), 32'd1);
    chk("ua_addr", mem_addr, 32'h204);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("ua_err", 32'(mem_err), 32'd0);
    step();
`endif

    // Load that never gets ready times out after 16 waiting cycles
    set_op(1'b1, 2'b01, 1'b0, 32'h300, 32'h0, 32'd8, 32'hB0);
    step();
    stall_cnt = 0;
    rw_seen = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      step();
      n++;
      if (RegWriteW) rw_seen = 1'b1;
    end
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("to_wait_cycles", 32'(n), 32'd16);
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_regwritew", 32'(rw_seen), 32'd0);
    chk("to_stall_cycles", 32'(stall_cnt), 32'd15);
    step();
    chk("to_err_pulse", 32'(mem_err), 32'd0);
    chk("to_req_idle", 32'(mem_req), 32'd0);

    // Ready in the same cycle the timeout would fire
    set_op(1'b1, 2'b01, 1'b0, 32'h400, 32'h0, 32'd11, 32'hC0);
    step();
    repeat (15) step();
    chk("rt_req_hold", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h5A5A_0001;
    #1 chk("rt_stall", 32'(StallM), 32'd0);
    step();
    mem_ready = 1'b0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rt_err", 32'(mem_err), 32'd0);
    chk("rt_readdataw", ReadDataW, 32'h5A5A_0001);
    chk("rt_regwritew", 32'(RegWriteW), 32'd1);
    chk("rt_rdw", RdW, 32'd11);
    step();

    // Reset while waiting discards the op
    set_op(1'b1, 2'b01, 1'b0, 32'h500, 32'h0, 32'd12, 32'hD0);
    step();
    step();
    chk("rw_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1 chk("rw_stall_in_rst", 32'(StallM), 32'd0);
    step();
    chk("rw_req_drop", 32'(mem_req), 32'd0);
    chk("rw_addr", mem_addr, 32'h0);
    chk("rw_regwritew", 32'(RegWriteW), 32'd0);
    chk("rw_aluw", ALUResultW, 32'h0);
    chk("rw_pcw", PCPlus4W, 32'h0);
    chk("rw_resultsrcw", 32'(ResultSrcW), 32'd0);
    rst = 1'b0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("rw_idle_req", 32'(mem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
